// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port RAM between the rv32i_core fetch port and its load/store port.
// Latency: request-to-ack is 2 cycles with zero-wait memory (1 transfer per 3 cycles); each mem_ready_i=0 cycle adds one.
// Backpressure: stall_o holds the core until its ack; ARB_ROUND_ROBIN_EN alternates tie-breaks, otherwise data always wins.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [2:0]        d_ctrl_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [2:0]        mem_ctrl_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              stall_o
);
    localparam logic [2:0] CTRL_WORD = 3'b010;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t              state_q, state_d;
    logic                gnt_d_q, gnt_d_d;
    logic                we_q, we_d;
    logic [2:0]          ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                pick_d;
    logic                grant;

    assign grant = (state_q == IDLE) && (if_req_i || d_req_i);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;

    // last_d_q=0 means the previous grant went to fetch, so the first tie goes to data.
    always_comb begin
        pick_d = d_req_i;
        if (d_req_i && if_req_i) begin
            pick_d = ~last_d_q;
        end
    end

    always_comb begin
        last_d_d = last_d_q;
        if (grant) begin
            last_d_d = pick_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    always_comb begin
        pick_d = d_req_i;
    end
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d_d    = gnt_d_q;
        we_d       = we_q;
        ctrl_d     = ctrl_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                    gnt_d_d = pick_d;
                    if (pick_d) begin
                        we_d    = d_we_i;
                        ctrl_d  = d_ctrl_i;
                        addr_d  = d_addr_i;
                        wdata_d = d_wdata_i;
                    end else begin
                        we_d    = 1'b0;
                        ctrl_d  = CTRL_WORD;
                        addr_d  = if_addr_i;
                        wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (mem_ready_i) begin
                    state_d = RESP;
                    // Stores leave the load-data register untouched.
                    if (!gnt_d_q) begin
                        if_rdata_d = mem_rdata_i;
                    end else if (!we_q) begin
                        d_rdata_d = mem_rdata_i;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_d_q    <= 1'b0;
            we_q       <= 1'b0;
            ctrl_q     <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_d_q    <= gnt_d_d;
            we_q       <= we_d;
            ctrl_q     <= ctrl_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_req_o   = (state_q == ISSUE);
    assign mem_we_o    = we_q;
    assign mem_ctrl_o  = ctrl_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_ack_o    = (state_q == RESP) && !gnt_d_q;
    assign d_ack_o     = (state_q == RESP) && gnt_d_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign stall_o     = (if_req_i && !if_ack_o) || (d_req_i && !d_ack_o);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-port memory between the rv32i_core instruction-fetch port and its load/store port.
- Sits between the core and the unified RAM. Accepts one request per side, serialises them onto one memory handshake, returns read data with a one-cycle ack pulse, and drives a stall to the core while any request is outstanding.

## Interface
Parameters:
- ADDR_W, 32, address width for all ports
- DATA_W, 32, data width for all ports

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request; held high until if_ack_o
- if_addr_i  in  ADDR_W  fetch address (core ins_address)
- if_rdata_o  out  DATA_W  fetched instruction; valid while if_ack_o=1
- if_ack_o  out  1  one-cycle fetch completion pulse
- d_req_i  in  1  data request; held high until d_ack_o
- d_we_i  in  1  1=store, 0=load (core RAM_rw)
- d_ctrl_i  in  3  access type byte/half/word/sign (core RAM_DATA_control)
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_rdata_o  out  DATA_W  load data; valid while d_ack_o=1
- d_ack_o  out  1  one-cycle data completion pulse
- mem_req_o  out  1  memory request
- mem_we_o, mem_ctrl_o (3), mem_addr_o (ADDR_W), mem_wdata_o (DATA_W)  out  command fields; stable while mem_req_o=1
- mem_rdata_i  in  DATA_W  memory read data; valid with mem_ready_i
- mem_ready_i  in  1  memory accepts and completes the transfer at this edge
- stall_o  out  1  core stall: (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o), combinational

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE:
  - If any request is pending, pick a winner, latch its address, we, ctrl and wdata into the command registers, go to ISSUE.
  - A fetch always forces mem_we_o=0 and mem_ctrl_o=3'b010 (word).
- ISSUE:
  - mem_req_o=1.
  - On an edge with mem_ready_i=1, capture mem_rdata_i into the winner's rdata register and go to RESP.
  - Otherwise stay in ISSUE with the command unchanged. Wait states are unbounded.
- RESP:
  - The winner's ack is 1 for exactly one cycle. mem_req_o=0.
  - Always return to IDLE. Requests are not re-sampled in RESP, so a requester may drop req or present a new request during its ack cycle.
- Stores: ack pulses the same way. d_rdata_o keeps its previous value.
- Arbitration on a tie (both requests high in IDLE): data wins. A load/store belongs to an older instruction than the fetch.
- A requester that drops req before ack (protocol violation): the transaction in flight still completes and ack still pulses.
- rdata registers hold their value until the next capture for that side.

## Timing
- Reset values: all outputs 0, rdata registers 0, FSM IDLE, last_grant=IF.
- Assert reset at any state: the in-flight transaction is abandoned, no ack is issued, mem_req_o drops asynchronously.
- Latency with zero-wait memory:
  - req high before edge E0 → mem_req_o high after E0.
  - mem_ready_i sampled at E1 → ack high for the cycle after E1.
  - Request-to-ack = 2 cycles; throughput = 1 transfer per 3 cycles.
- Each extra cycle of mem_ready_i=0 adds one cycle.
- mem_ready_i is ignored outside ISSUE.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Tie-break alternates using the last_grant register (updated on every grant).
  - First tie after reset goes to data.
  - With back-to-back ties, grants are D, IF, D, IF…
- Not defined: fixed data priority; last_grant is not implemented. A continuously requesting data port can starve fetch.

## Test plan
- Single fetch, mem_ready_i tied 1, if_addr_i=0x100, mem_rdata_i=0x00500093:
  - mem_addr_o=0x100, mem_we_o=0 one cycle after req.
  - if_ack_o=1 with if_rdata_o=0x00500093 two cycles after req.
  - stall_o=1 until the ack cycle.
- Store with 3 wait states, d_addr_i=0x2000, d_wdata_i=0xDEADBEEF, d_ctrl_i=3'b000:
  - mem command stable for 4 cycles.
  - d_ack_o pulses once; d_rdata_o unchanged.
- Simultaneous fetch 0x104 and load 0x2004:
  - Load issued first with d_ack_o.
  - Fetch issued in the following IDLE.
  - if_ack_o comes 3 cycles after d_ack_o.
- With ARB_ROUND_ROBIN_EN, both ports held requesting for 4 transfers:
  - Grant order D, IF, D, IF.
  - Without the macro, 4 data grants and no IF grant.
- Reset asserted mid-ISSUE with mem_ready_i=0:
  - mem_req_o=0 immediately; no ack.
  - After release, a pending request is re-arbitrated from IDLE.
- Requester drops req during its ack cycle and raises the other port's req: no duplicate ack, next transfer issued normally.
